instr_byte_queue: RTL
=====================

# instr_byte_queue

Instruction byte queue sitting directly upstream of the prefix/opcode decode stage in the instruction translator. It accepts 16-byte aligned fetch lines, keeps them in a small circular byte buffer, and presents a byte-aligned window that starts at the first byte of the current instruction. The window's low four bytes drive the prefix decoder's 32-bit `bits` input. Each cycle, downstream reports how many bytes it consumed, and the queue advances its read pointer by that amount.

## Interface
- `DEPTH`, 4: line slots in the buffer; must be a power of 2, at least 2.
- `WIN`, 8: window width in bytes presented to decode; must be a power of 2, at most 16.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `flush` in 1: discard all buffered bytes.
- `in_vld` in 1: fetch line valid.
- `in_rdy` out 1: a free line slot exists.
- `in_first` in 1: line starts a new stream (redirect target).
- `in_off` in 4: first useful byte within the line; honoured only with `in_first`.
- `in_data` in 128: fetch line, byte 0 in bits [7:0].
- `out_data` out WIN*8: window, byte at read pointer in bits [7:0].
- `out_cnt` out clog2(WIN)+1: number of valid window bytes, 0..WIN.
- `out_take` in clog2(WIN)+1: bytes consumed this cycle.

## Operation
- Storage: DEPTH×16 bytes, circular.
- Write pointer `wp`: line granular, clog2(DEPTH)+1 bits including a wrap bit.
- Read pointer `rp`: byte granular, clog2(DEPTH)+4+1 bits including a wrap bit.
- Byte count = `wp`·16 − `rp`, modulo 2^(ptr width). It ranges 0..DEPTH·16.
- `out_cnt` = min(WIN, byte count).
- `out_data` byte i = buffer[(`rp`+i) mod DEPTH·16]. Bytes at i ≥ `out_cnt` are don't-care.
  - The window may span the end of the buffer (wrap-around). Byte order must be preserved across the wrap.
- Write: on `in_vld` & `in_rdy`, the line goes to slot `wp` mod DEPTH, and `wp` increments.
- Read: `rp` += min(`out_take`, `out_cnt`). An excess take is clamped and never underflows the queue.
- `in_rdy` = (free line slots ≥ 1), computed from registered pointers only.
  - A line slot frees only when `rp` has moved past all 16 of its bytes.
- `in_first` with a handshake acts as an implicit flush of older content:
  - `wp` ← 1.
  - `rp` ← {0, `in_off`}.
  - The line is written to slot 0.
  - Any `out_take` in the same cycle is ignored.
- `in_first` is accepted regardless of queue fullness, i.e. `in_rdy` is forced to 1 while `in_first` is high.
- `flush` sets `wp` ← 0 and `rp` ← 0, and overrides every write and take in the same cycle.
  - `in_rdy` stays 1 during the flush, but the line presented that cycle is dropped. The fetch stage must not count it as accepted.
- Priority: `rst` > `flush` > `in_first` > normal write/take.
- Simultaneous write and take in one cycle:
  - Both pointers update.
  - A full queue whose take frees a slot still shows `in_rdy` = 0 that cycle, because it is registered. The slot is available the next cycle.

## Timing
- Reset values: `wp`=0, `rp`=0, `out_cnt`=0, `in_rdy`=1. `out_data` is don't-care but must not contain X after the first write.
- Reset applied mid-stream has the same effect as reset from power-on. Buffer contents are not cleared.
- Write-to-window latency: 1 cycle. A line accepted at edge N is visible in `out_data`/`out_cnt` after edge N.
- Take-to-window latency: 1 cycle. `out_take` sampled at edge N shifts the window after edge N.
- `out_data`/`out_cnt` are combinational from registered state and buffer only. There is no combinational path from `out_take` to them.

## Configuration
- `INSTRQ_BYPASS_EN`.
- Defined: when the queue is empty (or `in_first` is asserted) and `in_vld` is high, the window is driven combinationally from `in_data`.
  - `out_data` byte i = `in_data` byte (`in_off`+i) for `in_first`, or byte i otherwise.
  - `out_cnt` = min(WIN, 16 − offset).
  - An `out_take` that cycle is applied on top of the write, so `rp` ends at offset + take.
  - Latency is 0 cycles for the empty-queue case.
- Undefined: no bypass. The window always comes from the buffer with 1-cycle latency, and an `out_take` ≠ 0 while the queue is empty is clamped to 0.

## Test plan
- Reset, then a line 00..0F with `in_first` and `in_off`=3 → next cycle `out_cnt`=8 and `out_data` bytes 03..0A. Then take 8 → window 0B..0F with `out_cnt`=5.
- Fill 4 lines with no takes → `in_rdy`=0 and a 5th `in_vld` is ignored. Take 8 twice (16 bytes) → `in_rdy`=1 on the cycle after the second take.
- Wrap: place `rp` at byte 60 with 8+ bytes valid → `out_data` = bytes 60..63 then 0..3 of the buffer, in order.
- Take 8 while `out_cnt`=5 → `rp` advances by 5 and `out_cnt`=0 next cycle.
- `flush` asserted together with `in_vld` and `out_take`=4 → next cycle `out_cnt`=0, `in_rdy`=1, and the line is dropped. With the macro defined, an empty queue plus `in_vld` shows bytes with `out_cnt`=8 in the same cycle.

Source files
------------

// File: rtl/instr_byte_queue_if.sv
// Fetch-line / decode-window bundle of the instruction byte queue.
// master = fetch + decode side, slave = the queue itself.
interface instr_byte_queue_if #(
  parameter int WIN = 8
);
  localparam int CW = $clog2(WIN) + 1;

  logic           flush;
  logic           in_vld;
  logic           in_rdy;
  logic           in_first;
  logic [3:0]     in_off;
  logic [127:0]   in_data;
  logic [WIN*8-1:0] out_data;
  logic [CW-1:0]  out_cnt;
  logic [CW-1:0]  out_take;

  modport master (
    output flush, in_vld, in_first, in_off, in_data, out_take,
    input  in_rdy, out_data, out_cnt
  );

  modport slave (
    input  flush, in_vld, in_first, in_off, in_data, out_take,
    output in_rdy, out_data, out_cnt
  );
endinterface

// File: rtl/instr_byte_queue.sv
// Circular byte queue between fetch and prefix/opcode decode; presents a WIN-byte window at rp.
// Optional feature macro: INSTRQ_BYPASS_EN (combinational window from in_data when empty or redirecting).
module instr_byte_queue #(
  parameter int DEPTH = 4,
  parameter int WIN   = 8
) (
  input logic               clk,
  input logic               rst,
  instr_byte_queue_if.slave q
);
  localparam int LW = $clog2(DEPTH);
  localparam int BW = LW + 4;
  localparam int CW = $clog2(WIN) + 1;

  logic [7:0]    mem [DEPTH*16];
  logic [LW:0]   wp;
  logic [BW:0]   rp;
  logic [BW:0]   byte_cnt;
  logic [LW:0]   used_lines;
  logic          full;
  logic          wr_en;
  logic          first_wr;
  logic [LW-1:0] wr_slot;
  logic          byp;
  logic [3:0]    byp_off;
  logic [CW-1:0] byp_cnt;
  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] take_eff;

  assign byte_cnt   = {wp, 4'b0000} - rp;
  // A slot stays occupied until rp has left all 16 of its bytes, so lines are counted on rp's line index.
  assign used_lines = wp - rp[BW:4];
  assign full       = (used_lines == (LW+1)'(DEPTH));
  assign q.in_rdy   = ~full | q.in_first | q.flush;
  assign wr_en      = q.in_vld & q.in_rdy & ~q.flush;
  assign first_wr   = wr_en & q.in_first;
  assign wr_slot    = first_wr ? '0 : wp[LW-1:0];
  assign buf_cnt    = (byte_cnt >= (BW+1)'(WIN)) ? CW'(WIN) : byte_cnt[CW-1:0];

`ifdef INSTRQ_BYPASS_EN
  logic [4:0] byp_rem;
  assign byp     = q.in_vld & ~q.flush & (q.in_first | (byte_cnt == '0));
  assign byp_off = q.in_first ? q.in_off : 4'd0;
  assign byp_rem = 5'd16 - {1'b0, byp_off};
  assign byp_cnt = (byp_rem >= 5'(WIN)) ? CW'(WIN) : byp_rem[CW-1:0];
`else
  assign byp     = 1'b0;
  assign byp_off = 4'd0;
  assign byp_cnt = '0;
`endif

  assign cnt       = byp ? byp_cnt : buf_cnt;
  assign q.out_cnt = cnt;
  assign take_eff  = (q.out_take > cnt) ? cnt : q.out_take;

  // Bytes beyond cnt are zeroed so stale or never-written slots cannot leak X into decode.
  always_comb begin
    // NOTE: default first so every path assigns the whole window and no latch is inferred.
    q.out_data = '0;
    for (int i = 0; i < WIN; i++) begin
      if (CW'(i) < cnt) begin
        if (byp) q.out_data[8*i +: 8] = q.in_data[{byp_off + 4'(i), 3'b000} +: 8];
        else     q.out_data[8*i +: 8] = mem[BW'(rp[BW-1:0] + BW'(i))];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (q.flush) begin
      wp <= '0;
      rp <= '0;
    end else if (first_wr) begin
      wp <= (LW+1)'(1);
`ifdef INSTRQ_BYPASS_EN
      rp <= (BW+1)'(q.in_off) + (BW+1)'(take_eff);
`else
      rp <= (BW+1)'(q.in_off);
`endif
    end else begin
      if (wr_en) wp <= wp + (LW+1)'(1);
      rp <= rp + (BW+1)'(take_eff);
    end
  end

  // NOTE: the byte store has no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int b = 0; b < 16; b++) begin
        mem[{wr_slot, 4'(b)}] <= q.in_data[8*b +: 8];
      end
    end
  end
endmodule
